// File: rtl/pattern_merge_sched.sv
// pattern_merge_sched: round-robin scheduler that time-shares one pattern datapath among NREQ requesters.
// Optional macro PMS_FLUSH_EN: zero dp_in for LAT cycles after each response to drain the datapath.
module pattern_merge_sched #(
   parameter int NREQ  = 4,
   parameter int IN_W  = 11,
   parameter int OUT_W = 8,
   parameter int LAT   = 2,
   parameter int ID_W  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic                 blif_clk_net,
   input  logic                 blif_reset_net,
   input  logic [NREQ-1:0]      req_valid,
   input  logic [NREQ*IN_W-1:0] req_data,
   output logic [NREQ-1:0]      req_ready,
   output logic [IN_W-1:0]      dp_in,
   input  logic [OUT_W-1:0]     dp_out,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [ID_W-1:0]      rsp_id,
   output logic [OUT_W-1:0]     rsp_data,
   output logic                 busy
);
   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] DRIVE = 2'd1;
   localparam logic [1:0] RESP  = 2'd2;
   localparam logic [1:0] FLUSH = 2'd3;
   logic [1:0]       r_state;
   logic [ID_W-1:0]  r_rr_ptr;
   logic [3:0]       r_cnt;
   logic [IN_W-1:0]  r_job_data;
   logic [ID_W-1:0]  r_job_id;
   logic [IN_W-1:0]  r_dp_in;
   logic             r_rsp_valid;
   logic [ID_W-1:0]  r_rsp_id;
   logic [OUT_W-1:0] r_rsp_data;
   logic             r_busy;
   logic [NREQ-1:0]  w_grant;
   logic [ID_W-1:0]  w_gid;
   logic             w_hit;
   int               w_pos;
   logic [IN_W-1:0]  w_sel;
   logic             w_last;
   // search upward from rr_ptr, wrapping modulo NREQ
   always_comb begin
      w_gid = '0;
      w_hit = 1'b0;
      w_pos = 0;
      for (int k = 0; k < NREQ; k++) begin
         w_pos = int'(r_rr_ptr) + k;
         if (w_pos >= NREQ) w_pos = w_pos - NREQ;
         if (!w_hit && req_valid[w_pos[ID_W-1:0]]) begin
            w_hit = 1'b1;
            w_gid = w_pos[ID_W-1:0];
         end
      end
      w_grant = w_hit ? (NREQ'(1) << w_gid) : '0;
   end
   assign w_sel     = req_data[int'(w_gid)*IN_W +: IN_W];
   assign w_last    = (r_cnt == 4'(LAT-1));
   assign req_ready = (r_state == IDLE && blif_reset_net) ? w_grant : '0;
   assign dp_in     = r_dp_in;
   assign rsp_valid = r_rsp_valid;
   assign rsp_id    = r_rsp_id;
   assign rsp_data  = r_rsp_data;
   assign busy      = r_busy;
   always_ff @(posedge blif_clk_net) begin
      if (!blif_reset_net) begin
         r_state     <= IDLE;
         r_rr_ptr    <= '0;
         r_cnt       <= '0;
         r_job_data  <= '0;
         r_job_id    <= '0;
         r_dp_in     <= '0;
         r_rsp_valid <= 1'b0;
         r_rsp_id    <= '0;
         r_rsp_data  <= '0;
         r_busy      <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               r_dp_in <= '0;
               if (w_hit) begin
                  r_job_data <= w_sel;
                  r_job_id   <= w_gid;
                  r_dp_in    <= w_sel;
                  r_rr_ptr   <= (w_gid == ID_W'(NREQ-1)) ? '0 : w_gid + 1'b1;
                  r_cnt      <= '0;
                  r_state    <= DRIVE;
                  r_busy     <= 1'b1;
               end
            end
            DRIVE: begin
               r_cnt <= r_cnt + 1'b1;
               if (w_last) begin
                  r_rsp_data  <= dp_out;
                  r_rsp_id    <= r_job_id;
                  r_rsp_valid <= 1'b1;
                  r_state     <= RESP;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  r_rsp_valid <= 1'b0;
`ifdef PMS_FLUSH_EN
                  r_cnt   <= '0;
                  r_dp_in <= '0;
                  r_state <= FLUSH;
`else
                  r_dp_in <= '0;
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
`endif
               end
            end
`ifdef PMS_FLUSH_EN
            FLUSH: begin
               r_cnt <= r_cnt + 1'b1;
               if (w_last) begin
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
               end
            end
`endif
            default: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
               r_dp_in <= '0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_pattern_merge_sched.sv
// tb_pattern_merge_sched: directed checks of grant order, timing, backpressure and reset of pattern_merge_sched.
module tb_pattern_merge_sched;
   localparam int NREQ = 4;
`ifdef PMS_FLUSH_EN
   localparam int FL = 2;
`else
   localparam int FL = 0;
`endif
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [3:0]  req_valid = '0;
   logic [43:0] req_data = {11'h4D8, 11'h5A3, 11'h2B7, 11'h1C5};
   logic [3:0]  req_ready;
   logic [10:0] dp_in;
   logic [7:0]  dp_out = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b1;
   logic [1:0]  rsp_id;
   logic [7:0]  rsp_data;
   logic        busy;
   int total = 0;
   int bad = 0;

   pattern_merge_sched dut (
      .blif_clk_net(clk), .blif_reset_net(rst_n), .req_valid(req_valid), .req_data(req_data),
      .req_ready(req_ready), .dp_in(dp_in), .dp_out(dp_out), .rsp_valid(rsp_valid),
      .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data), .busy(busy));

   always #5 clk = ~clk;
   // datapath stand-in: one register stage of the low input byte
   always_ff @(posedge clk) dp_out <= dp_in[7:0];

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      req_valid = '0;
      rsp_ready = 1'b1;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic wait_rsp();
      int n = 0;
      while (!rsp_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      total++;
      if (!rsp_valid) begin
         bad++;
         $display("FAIL wait_rsp: rsp_valid=%b required 1 within 20 cycles", rsp_valid);
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst_n = 1'b0;
      req_valid = 4'hF;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         total++;
         if ({req_ready, rsp_valid, dp_in, busy} !== 17'd0) begin
            bad++;
            $display("FAIL reset_state c%0d: req_ready=%b rsp_valid=%b dp_in=%h busy=%b required all 0",
                     c, req_ready, rsp_valid, dp_in, busy);
         end
      end
      rst_n = 1'b1;
      #1;
      total++;
      if (req_ready !== 4'b0001) begin
         bad++;
         $display("FAIL reset_first_grant: req_ready=%b required 0001", req_ready);
      end
      @(negedge clk);
      req_valid = '0;
      total++;
      if (dp_in !== 11'h1C5 || busy !== 1'b1) begin
         bad++;
         $display("FAIL reset_first_job: dp_in=%h busy=%b required 1c5 1", dp_in, busy);
      end
      repeat (8) @(negedge clk);
   endtask

   task automatic test_single();
      do_reset();
      req_valid = 4'b0100;
      #1;
      total++;
      if (req_ready !== 4'b0100) begin
         bad++;
         $display("FAIL single_grant: req_ready=%b required 0100", req_ready);
      end
      @(negedge clk);
      req_valid = '0;
      total++;
      if (dp_in !== 11'h5A3 || req_ready !== 4'b0 || rsp_valid !== 1'b0) begin
         bad++;
         $display("FAIL single_t1: dp_in=%h req_ready=%b rsp_valid=%b required 5a3 0000 0", dp_in, req_ready, rsp_valid);
      end
      @(negedge clk);
      total++;
      if (rsp_valid !== 1'b0 || dp_in !== 11'h5A3) begin
         bad++;
         $display("FAIL single_t2: rsp_valid=%b dp_in=%h required 0 5a3", rsp_valid, dp_in);
      end
      @(negedge clk);
      total++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_data !== 8'hA3) begin
         bad++;
         $display("FAIL single_rsp: rsp_valid=%b rsp_id=%0d rsp_data=%h required 1 2 a3", rsp_valid, rsp_id, rsp_data);
      end
      @(negedge clk);
      total++;
      if (rsp_valid !== 1'b0) begin
         bad++;
         $display("FAIL single_done: rsp_valid=%b required 0", rsp_valid);
      end
      repeat (6) @(negedge clk);
   endtask

   task automatic test_round_robin();
      do_reset();
      req_valid = 4'hF;
      #1;
      for (int j = 0; j < 5; j++) begin
         int n = 0;
         while (req_ready == 4'b0 && n < 20) begin
            @(negedge clk);
            n++;
         end
         total++;
         if (req_ready !== (4'b0001 << (j % 4))) begin
            bad++;
            $display("FAIL rr_grant%0d: req_ready=%b required %b", j, req_ready, 4'b0001 << (j % 4));
         end
         @(negedge clk);
      end
      req_valid = '0;
      repeat (10) @(negedge clk);
   endtask

   task automatic test_backpressure();
      do_reset();
      rsp_ready = 1'b0;
      req_valid = 4'b0011;
      #1;
      total++;
      if (req_ready !== 4'b0001) begin
         bad++;
         $display("FAIL bp_grant: req_ready=%b required 0001", req_ready);
      end
      @(negedge clk);
      wait_rsp();
      for (int c = 0; c < 5; c++) begin
         total++;
         if (rsp_valid !== 1'b1 || rsp_data !== 8'hC5 || rsp_id !== 2'd0 || req_ready !== 4'b0) begin
            bad++;
            $display("FAIL bp_hold c%0d: rsp_valid=%b rsp_data=%h rsp_id=%0d req_ready=%b required 1 c5 0 0000",
                     c, rsp_valid, rsp_data, rsp_id, req_ready);
         end
         @(negedge clk);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      for (int k = 0; k < FL; k++) begin
         total++;
         if (req_ready !== 4'b0) begin
            bad++;
            $display("FAIL bp_flush%0d: req_ready=%b required 0000", k, req_ready);
         end
         @(negedge clk);
      end
      total++;
      if (req_ready !== 4'b0010) begin
         bad++;
         $display("FAIL bp_next_grant: req_ready=%b required 0010", req_ready);
      end
      req_valid = '0;
      repeat (10) @(negedge clk);
   endtask

   task automatic test_reset_mid();
      logic seen = 1'b0;
      do_reset();
      req_valid = 4'b0100;
      @(negedge clk);
      req_valid = '0;
      rst_n = 1'b0;
      @(negedge clk);
      total++;
      if (busy !== 1'b0 || rsp_valid !== 1'b0 || dp_in !== 11'd0) begin
         bad++;
         $display("FAIL mid_reset_state: busy=%b rsp_valid=%b dp_in=%h required 0 0 000", busy, rsp_valid, dp_in);
      end
      rst_n = 1'b1;
      repeat (8) begin
         @(negedge clk);
         if (rsp_valid) seen = 1'b1;
      end
      total++;
      if (seen !== 1'b0) begin
         bad++;
         $display("FAIL mid_reset_no_rsp: rsp seen=%b required 0", seen);
      end
      req_valid = 4'hF;
      #1;
      total++;
      if (req_ready !== 4'b0001) begin
         bad++;
         $display("FAIL mid_reset_rr_ptr: req_ready=%b required 0001", req_ready);
      end
      req_valid = '0;
      repeat (2) @(negedge clk);
   endtask

`ifdef PMS_FLUSH_EN
   task automatic test_flush();
      do_reset();
      req_valid = 4'b0011;
      @(negedge clk);
      req_valid = 4'b0010;
      wait_rsp();
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         total++;
         if (dp_in !== 11'd0 || busy !== 1'b1 || req_ready !== 4'b0) begin
            bad++;
            $display("FAIL flush_zero%0d: dp_in=%h busy=%b req_ready=%b required 000 1 0000", k, dp_in, busy, req_ready);
         end
         @(negedge clk);
      end
      total++;
      if (req_ready !== 4'b0010) begin
         bad++;
         $display("FAIL flush_next_grant: req_ready=%b required 0010", req_ready);
      end
      @(negedge clk);
      req_valid = '0;
      wait_rsp();
      total++;
      if (rsp_data !== 8'hB7 || rsp_id !== 2'd1) begin
         bad++;
         $display("FAIL flush_second: rsp_data=%h rsp_id=%0d required b7 1", rsp_data, rsp_id);
      end
      repeat (8) @(negedge clk);
   endtask
`endif

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_backpressure();
      test_reset_mid();
`ifdef PMS_FLUSH_EN
      test_flush();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
